test_status_mmio: RTL and testbench

//  Memory-mapped test-status responder on the single-cycle core's data-memory bus; the hardware end of the

---
 rtl/test_status_mmio_pkg.sv | 21 ++
 rtl/test_status_mmio_watchdog.sv | 37 +++
 rtl/test_status_mmio.sv | 115 +++++++++++
 tb/tb_test_status_mmio.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_mmio_pkg.sv
// Shared definitions for the test-status MMIO responder: FSM encoding and
// the default bus addresses of its three registers.
package test_status_mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_1004;
    localparam logic [31:0] CYCLE_ADDR_DEF   = 32'h0000_1008;

    function automatic logic is_terminal(state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/test_status_mmio_watchdog.sv
// Saturating RUN-cycle watchdog; expire is raised during the TIMEOUT-th
// enabled cycle so the owner can transition on that same edge.
module test_status_mmio_watchdog #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/test_status_mmio.sv
// Test-status responder on the core data bus: snoops stores to report
// PASS/FAIL/TIMEOUT and console bytes, and serves a read-only cycle counter.
module test_status_mmio
    import test_status_mmio_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] CYCLE_ADDR   = CYCLE_ADDR_DEF,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             mem_hit,
    output logic [31:0]      mem_rdata,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             char_valid,
    output logic [7:0]       char_data
);

    state_e             state_q, state_d;
    logic [30:0]        fail_code_q, fail_code_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               char_valid_q, char_valid_d;
    logic [7:0]         char_data_q, char_data_d;

    logic hit_tohost, hit_console, hit_cycle;
    logic in_run, run_store, term_wr, wd_expire;

    assign hit_tohost  = (mem_addr == TOHOST_ADDR);
    assign hit_console = (mem_addr == CONSOLE_ADDR);
    assign hit_cycle   = (mem_addr == CYCLE_ADDR);
    assign mem_hit     = hit_tohost || hit_console || hit_cycle;
    assign mem_rdata   = hit_cycle ? 32'(cycle_count_q) : 32'h0;

    assign in_run    = (state_q == ST_RUN);
    assign run_store = in_run && mem_we;
    // Only odd TOHOST values end the test; even values are reserved/ignored.
    assign term_wr   = run_store && hit_tohost && mem_wdata[0];

    test_status_mmio_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (in_run),
        .clr    (state_q == ST_IDLE),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_RUN;
            ST_RUN: begin
                // A terminating store beats a watchdog expiry in the same cycle.
                if (term_wr) begin
                    if (mem_wdata == 32'd1) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = mem_wdata[31:1];
                    end
                end else if (wd_expire) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (in_run && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        char_valid_d = run_store && hit_console;
        char_data_d  = char_valid_d ? mem_wdata[7:0] : char_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            char_valid_q  <= 1'b0;
            char_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            char_valid_q  <= char_valid_d;
            char_data_q   <= char_data_d;
        end
    end

    assign done        = is_terminal(state_q);
    assign pass        = (state_q == ST_PASS);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign char_valid  = char_valid_q;
    assign char_data   = char_data_q;

endmodule

// File: tb/tb_test_status_mmio.sv
// Scoreboard bench for test_status_mmio: stimulus queues expected snapshots
// and console bytes; a negedge monitor pops and compares them.
module tb_test_status_mmio;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE = 32'h0000_1004;
    localparam logic [31:0] CYC     = 32'h0000_1008;

    logic        clk = 1'b0;
    logic        rst, run, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_hit, done, pass, timeout, char_valid;
    logic [31:0] mem_rdata, cycle_count;
    logic [30:0] fail_code;
    logic [7:0]  char_data;

    test_status_mmio #(
        .TIMEOUT (20),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_hit     (mem_hit),
        .mem_rdata   (mem_rdata),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .char_valid  (char_valid),
        .char_data   (char_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        tmo;
        logic [30:0] fc;
        logic [31:0] cc;
        logic        hit;
        logic [31:0] rdata;
        logic        cv;
        logic [7:0]  cd;
    } snap_t;

    snap_t      exp_q[$];
    string      name_q[$];
    logic [7:0] char_q[$];
    logic [7:0] exp_cd;
    int         n_vec = 0;
    int         n_bad = 0;

    always @(negedge clk) begin
        snap_t e;
        string nm;
        logic [7:0] c;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (done !== e.done || pass !== e.pass || timeout !== e.tmo ||
                fail_code !== e.fc || cycle_count !== e.cc || mem_hit !== e.hit ||
                mem_rdata !== e.rdata || char_valid !== e.cv || char_data !== e.cd) begin
                n_bad++;
                $display("FAIL %s: got done=%0b pass=%0b tmo=%0b fc=%0d cc=%0d hit=%0b rd=%0h cv=%0b cd=%0h; want done=%0b pass=%0b tmo=%0b fc=%0d cc=%0d hit=%0b rd=%0h cv=%0b cd=%0h",
                         nm, done, pass, timeout, fail_code, cycle_count, mem_hit, mem_rdata,
                         char_valid, char_data, e.done, e.pass, e.tmo, e.fc, e.cc, e.hit,
                         e.rdata, e.cv, e.cd);
            end
        end
        if (char_valid === 1'b1) begin
            n_vec++;
            if (char_q.size() == 0) begin
                n_bad++;
                $display("FAIL char_unexpected: got pulse data=%0h, want no pulse", char_data);
            end else begin
                c = char_q.pop_front();
                if (char_data !== c) begin
                    n_bad++;
                    $display("FAIL char_data: got %0h, want %0h", char_data, c);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    // Queue the expected outputs for the current half-cycle; decode/read values
    // come from the bus the bench is driving right now.
    task automatic chk(input string nm, input logic d, input logic p, input logic t,
                       input logic [30:0] fc, input logic [31:0] cc, input logic cv);
        snap_t e;
        e.done  = d;
        e.pass  = p;
        e.tmo   = t;
        e.fc    = fc;
        e.cc    = cc;
        e.hit   = (mem_addr == TOHOST) || (mem_addr == CONSOLE) || (mem_addr == CYC);
        e.rdata = (mem_addr == CYC) ? cc : 32'h0;
        e.cv    = cv;
        e.cd    = exp_cd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; run = 1'b0; exp_cd = 8'h00;
        bus(1'b0, CYC, 32'h0);

        // reset and idle
        tick(3);
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(10);
        chk("idle_no_run", 0, 0, 0, 0, 0, 0);

        // PASS after 5 RUN cycles
        run = 1'b1;
        tick(1);
        chk("run_entry", 0, 0, 0, 0, 0, 0);
        tick(5);
        bus(1'b1, TOHOST, 32'h1);
        chk("pass_store_cycle", 0, 0, 0, 0, 5, 0);
        tick(1);
        bus(1'b0, CYC, 32'h0);
        chk("pass", 1, 1, 0, 0, 6, 0);
        tick(3);
        chk("pass_frozen", 1, 1, 0, 0, 6, 0);

        // FAIL code, ignored stores, absorbing state
        rst = 1'b1;
        tick(1);
        chk("rst_in_pass", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        bus(1'b1, TOHOST, 32'h0);
        tick(1);
        bus(1'b1, CYC, 32'hDEAD_BEEF);
        chk("even_tohost_ignored", 0, 0, 0, 0, 1, 0);
        tick(1);
        bus(1'b1, TOHOST, 32'h7);
        tick(1);
        bus(1'b1, TOHOST, 32'h1);
        chk("fail_code", 1, 0, 0, 3, 3, 0);
        tick(1);
        bus(1'b0, CYC, 32'h0);
        chk("fail_absorbing", 1, 0, 0, 3, 3, 0);

        // watchdog expiry on the 20th RUN cycle
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        tick(19);
        chk("pre_expiry", 0, 0, 0, 0, 19, 0);
        tick(1);
        chk("timeout", 1, 0, 1, 0, 20, 0);
        tick(2);
        chk("timeout_frozen", 1, 0, 1, 0, 20, 0);

        // terminating write in the expiry cycle wins
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        tick(19);
        bus(1'b1, TOHOST, 32'h1);
        tick(1);
        bus(1'b0, CYC, 32'h0);
        chk("expiry_vs_pass", 1, 1, 0, 0, 20, 0);

        // console bytes back to back, then PASS without a pulse
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        bus(1'b1, CONSOLE, 32'h1234_5648);
        char_q.push_back(8'h48);
        tick(1);
        exp_cd = 8'h48;
        bus(1'b1, CONSOLE, 32'h0000_0069);
        char_q.push_back(8'h69);
        chk("char_h", 0, 0, 0, 0, 1, 1);
        tick(1);
        exp_cd = 8'h69;
        bus(1'b1, TOHOST, 32'h1);
        chk("char_i", 0, 0, 0, 0, 2, 1);
        tick(1);
        bus(1'b1, CONSOLE, 32'h55);
        chk("tohost_no_pulse", 1, 1, 0, 0, 3, 0);
        tick(1);
        bus(1'b0, CYC, 32'h0);
        chk("console_outside_run", 1, 1, 0, 0, 3, 0);

        // reset in a terminal state and mid-RUN, then restart
        rst = 1'b1;
        tick(1);
        exp_cd = 8'h00;
        chk("rst_clears_char", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        tick(3);
        chk("mid_run", 0, 0, 0, 0, 3, 0);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_run", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        tick(2);
        chk("restart_count", 0, 0, 0, 0, 2, 0);

        tick(2);
        n_vec++;
        if (char_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d chars %0d snapshots pending, want 0 0",
                     char_q.size(), exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
